// File: rtl/l2_port_arbiter_if.sv
// Bundles the L1-requester side and the L2 CPU-side port of l2_port_arbiter.
// slave = the arbiter's view; master = the L1 caches plus the L2 cache.
interface l2_port_arbiter_if #(
    parameter int NUM_REQ       = 2,
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int L1_BLOCK_SIZE = 16
);
    localparam int BW = L1_BLOCK_SIZE * DATA_WIDTH;
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]            req_read;
    logic [NUM_REQ-1:0]            req_write;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*BW-1:0]         req_data;
    logic [NUM_REQ-1:0]            resp_valid;
    logic [BW-1:0]                 resp_data;
    logic [GW-1:0]                 grant_id;
    logic                          busy;
    logic [ADDR_WIDTH-1:0]         l2_cache_addr;
    logic [BW-1:0]                 l2_cache_data_in;
    logic                          l2_cache_read;
    logic                          l2_cache_write;
    logic [BW-1:0]                 l2_cache_data_out;
    logic                          l2_cache_ready;

    modport slave (
        input  req_read, req_write, req_addr, req_data, l2_cache_data_out, l2_cache_ready,
        output resp_valid, resp_data, grant_id, busy,
               l2_cache_addr, l2_cache_data_in, l2_cache_read, l2_cache_write
    );

    modport master (
        output req_read, req_write, req_addr, req_data, l2_cache_data_out, l2_cache_ready,
        input  resp_valid, resp_data, grant_id, busy,
               l2_cache_addr, l2_cache_data_in, l2_cache_read, l2_cache_write
    );
endinterface

// File: rtl/l2_port_arbiter.sv
// Round-robin arbiter sharing the single L2 CPU-side port among NUM_REQ L1 caches.
// Define L2_ARB_PERF_EN to add the per-requester perf_grants / perf_wait_cycles counters.
module l2_port_arbiter #(
    parameter int NUM_REQ       = 2,
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int L1_BLOCK_SIZE = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    l2_port_arbiter_if.slave      bus
`ifdef L2_ARB_PERF_EN
    ,
    output logic [NUM_REQ*32-1:0] perf_grants,
    output logic [NUM_REQ*32-1:0] perf_wait_cycles
`endif
);
    localparam int BW = L1_BLOCK_SIZE * DATA_WIDTH;
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                r_state;
    logic [GW-1:0]         r_rr_ptr;
    logic [GW-1:0]         r_grant_id;
    logic [NUM_REQ-1:0]    r_resp_valid;
    logic [BW-1:0]         r_resp_data;
    logic                  r_busy;
    logic [ADDR_WIDTH-1:0] r_l2_addr;
    logic [BW-1:0]         r_l2_data_in;
    logic                  r_l2_read;
    logic                  r_l2_write;

    logic [NUM_REQ-1:0]                 w_req;
    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] w_addr_arr;
    logic [NUM_REQ-1:0][BW-1:0]         w_data_arr;
    logic                               w_found;
    logic [GW-1:0]                      w_pick;
    int                                 w_idx;

    assign w_req      = bus.req_read | bus.req_write;
    assign w_addr_arr = bus.req_addr;
    assign w_data_arr = bus.req_data;

    // Cyclic search from the RR pointer; walking backwards lets the closest hit win.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = (int'(r_rr_ptr) + k) % NUM_REQ;
            if (w_req[GW'(w_idx)]) begin
                w_found = 1'b1;
                w_pick  = GW'(w_idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_rr_ptr     <= '0;
            r_grant_id   <= '0;
            r_resp_valid <= '0;
            r_resp_data  <= '0;
            r_busy       <= 1'b0;
            r_l2_addr    <= '0;
            r_l2_data_in <= '0;
            r_l2_read    <= 1'b0;
            r_l2_write   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant_id   <= w_pick;
                        r_l2_addr    <= w_addr_arr[w_pick];
                        r_l2_data_in <= w_data_arr[w_pick];
                        // A request with both read and write set is a write.
                        r_l2_write   <= bus.req_write[w_pick];
                        r_l2_read    <= ~bus.req_write[w_pick];
                        r_busy       <= 1'b1;
                        r_state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_l2_read  <= 1'b0;
                    r_l2_write <= 1'b0;
                    r_state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.l2_cache_ready) begin
                        r_resp_data  <= bus.l2_cache_data_out;
                        r_resp_valid <= NUM_REQ'(1) << r_grant_id;
                        r_rr_ptr     <= (r_grant_id == GW'(NUM_REQ - 1)) ? '0 : r_grant_id + 1'b1;
                        r_state      <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_resp_valid <= '0;
                    r_busy       <= 1'b0;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.resp_valid       = r_resp_valid;
    assign bus.resp_data        = r_resp_data;
    assign bus.grant_id         = r_grant_id;
    assign bus.busy             = r_busy;
    assign bus.l2_cache_addr    = r_l2_addr;
    assign bus.l2_cache_data_in = r_l2_data_in;
    assign bus.l2_cache_read    = r_l2_read;
    assign bus.l2_cache_write   = r_l2_write;

`ifdef L2_ARB_PERF_EN
    logic [NUM_REQ-1:0][31:0] r_perf_grants;
    logic [NUM_REQ-1:0][31:0] r_perf_wait;

    // Saturating counters: grants taken, and cycles spent pending without a response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_grants <= '0;
            r_perf_wait   <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (r_state == S_IDLE && w_found && w_pick == GW'(i) && r_perf_grants[i] != '1)
                    r_perf_grants[i] <= r_perf_grants[i] + 32'd1;
                if (w_req[i] && !r_resp_valid[i] && r_perf_wait[i] != '1)
                    r_perf_wait[i] <= r_perf_wait[i] + 32'd1;
            end
        end
    end

    assign perf_grants      = r_perf_grants;
    assign perf_wait_cycles = r_perf_wait;
`endif
endmodule

// File: doc/l2_port_arbiter.md
Name: l2_port_arbiter

Overview:
- Shares the single L2 cache CPU-side port between NUM_REQ L1 requesters, e.g. I-cache = 0 and D-cache = 1.
- Uses round-robin arbitration and latches the winner's address and block.
- Issues a one-cycle read/write pulse to L2, waits for l2_cache_ready, then returns the line to the winner with a one-cycle response pulse.
- Sits between the L1 caches and L2_cache; the L2 memory side is untouched.

Parameters:
- NUM_REQ, 2, number of requesters (>=2).
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, word width.
- L1_BLOCK_SIZE, 16, words per L1 block transferred.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_read  in  NUM_REQ  per-requester read request (level).
- req_write  in  NUM_REQ  per-requester write request (level).
- req_addr  in  NUM_REQ*ADDR_WIDTH  flattened addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_data  in  NUM_REQ*L1_BLOCK_SIZE*DATA_WIDTH  flattened write blocks, same slicing scheme.
- resp_valid  out  NUM_REQ  one-hot, one-cycle completion pulse.
- resp_data  out  L1_BLOCK_SIZE*DATA_WIDTH  returned block; valid while resp_valid is set.
- grant_id  out  max(1,$clog2(NUM_REQ))  index of the current or last granted requester.
- busy  out  1  high in any state other than IDLE.
- l2_cache_addr  out  ADDR_WIDTH  to L2.
- l2_cache_data_in  out  L1_BLOCK_SIZE*DATA_WIDTH  to L2.
- l2_cache_read  out  1  one-cycle pulse.
- l2_cache_write  out  1  one-cycle pulse.
- l2_cache_data_out  in  L1_BLOCK_SIZE*DATA_WIDTH  from L2.
- l2_cache_ready  in  1  one-cycle completion from L2.

Behaviour:
- Reset (async, any state, including mid-transaction): all outputs are 0 (resp_valid, resp_data, grant_id, busy, l2_cache_*). State goes to IDLE and the RR pointer to 0. An outstanding L2 transaction is abandoned; its later l2_cache_ready is ignored because the FSM is in IDLE.
- Requester contract:
  - req_i = req_read[i] | req_write[i].
  - Once raised, the requester holds its request and payload until it sees resp_valid[i], then drops the request the next cycle.
  - If both read and write are set, the request is treated as a write.
- FSM, all outputs registered:
  - IDLE: if any req_i, pick the first requester at or after the RR pointer (cyclic search). Latch its addr/data into l2_cache_addr/l2_cache_data_in. Set grant_id, set l2_cache_write (if write) else l2_cache_read, busy=1. Go to ISSUE.
  - ISSUE: lasts one cycle, during which the read or write pulse is high. Clear l2_cache_read/write on exit. Go to WAIT.
  - WAIT: hold addr/data stable. When l2_cache_ready=1: capture l2_cache_data_out into resp_data, set resp_valid[grant_id], RR pointer = grant_id+1 mod NUM_REQ. Go to DONE.
  - DONE: resp_valid is high this cycle only; clear it on exit. busy=0. Go to IDLE. No arbitration happens in DONE, so the finishing requester has dropped its request before the next pick.
- Command pulses are single-cycle so L2 never re-samples a stale request when it returns to IDLE.
- Latency: request seen in IDLE at cycle T → read pulse at T+1 → resp_valid one cycle after l2_cache_ready is sampled.
- Minimum occupancy is 4 cycles per transaction (IDLE, ISSUE, WAIT, DONE).
- l2_cache_ready outside WAIT is ignored.
- Requests arriving during a transaction wait; none are lost or reordered per requester.
- Starvation-free: with all requesters continuously active, grants rotate 0,1,…,NUM_REQ-1.

Optional Feature:
- Macro L2_ARB_PERF_EN.
- When defined, the block adds outputs perf_grants (NUM_REQ*32, per-requester granted-transaction count) and perf_wait_cycles (NUM_REQ*32, per-requester count of cycles with req_i high and resp_valid[i] low).
  - Both counters saturate at 0xFFFFFFFF and reset to 0.
- When undefined, these ports and registers do not exist and the behaviour is otherwise identical.

Test Plan:
- Reset then idle → all outputs 0. Async rst_n low in WAIT → immediate return to outputs 0. A later l2_cache_ready pulse produces no resp_valid.
- Single read: requester 0 reads 0x0000_1040; stub L2 returns ready 6 cycles after the pulse with data word k = 0xA0+k.
  - l2_cache_read is high exactly 1 cycle with addr 0x1040.
  - resp_valid = 2'b01 for 1 cycle, one cycle after ready, with matching resp_data.
- Write: requester 1 writes to 0x2000 with block 0x55…55 → l2_cache_write pulses once, l2_cache_read stays 0, l2_cache_data_in = 0x55…55, resp_valid = 2'b10.
- Simultaneous: both requesters raise requests at reset exit → grants in order 0 then 1. Repeating continuously gives 0,1,0,1, with grant_id matching.
- Ready spurious or in ISSUE: pulse l2_cache_ready in IDLE → no response. Hold the request during a 20-cycle L2 miss → exactly one command pulse and one resp_valid.
- With L2_ARB_PERF_EN: 3 transactions for requester 0 and 2 for requester 1 → perf_grants = {2,3}. perf_wait_cycles equals the bench-counted pending cycles.
